// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Round-robin arbiter that shares one WIDTH-bit serial shift-out datapath
//   between two parallel-data requesters. The granted word is captured and
//   shifted out MSB first, each bit held for DIV clocks.
//
// Parameters
//   WIDTH  bits per frame (>= 2)
//   DIV    clock cycles per serial bit (>= 1)
//
// Ports
//   C          clock, rising edge
//   R          synchronous active-high reset
//   REQ0/REQ1  level requests, held until the matching ACK
//   D0/D1      request words, stable while the request is high
//   ACK0/ACK1  one-cycle pulse in the first cycle of the granted frame
//   SO         serial data, MSB first; 0 when not shifting
//   BUSY       high while a frame is on SO
//   GNT        index of the requester owning the current/last frame
//   DONE       one-cycle pulse after the last bit of a frame
module serial_tx_arbiter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             ACK1,
  output logic             SO,
  output logic             BUSY,
  output logic             GNT,
  output logic             DONE
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [DW-1:0]    divcnt;
  logic             last;
  logic             gnt_q;
  logic             ack0_q, ack1_q;

  logic             any_req;
  logic             pick;
  logic             div_end;
  logic             bit_end;

  assign any_req = REQ0 | REQ1;
  // On a tie the requester that did not own the previous frame wins;
  // otherwise the single active requester is picked.
  assign pick    = (REQ0 && REQ1) ? ~last : REQ1;
  // With DIV=1 every SHIFT cycle is a bit boundary; the counter stays at 0.
  assign div_end = (DIV == 1) ? 1'b1 : (divcnt == DW'(DIV - 1));
  assign bit_end = (bitcnt == BW'(WIDTH - 1));

  always_ff @(posedge C) begin
    if (R) begin
      state  <= S_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      last   <= 1'b1;
      gnt_q  <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            shreg  <= pick ? D1 : D0;
            gnt_q  <= pick;
            last   <= pick;
            ack0_q <= ~pick;
            ack1_q <= pick;
            bitcnt <= '0;
            divcnt <= '0;
          end
        end
        S_SHIFT: begin
          if (div_end) begin
            divcnt <= '0;
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
            bitcnt <= bitcnt + 1'b1;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    SO        = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        BUSY = 1'b1;
        SO   = shreg[WIDTH-1];
        if (div_end && bit_end) state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ACK0 = ack0_q;
  assign ACK1 = ack1_q;
  assign GNT  = gnt_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: three instances (DIV = 1, 2, 4) with
// directed stimulus; expected frames are queued per instance and a monitor
// checks every cycle of each frame against the queued word.
module tb_serial_tx_arbiter;

  typedef struct packed {
    logic       idx;
    logic [7:0] word;
  } exp_t;

  logic            c;
  logic [2:0]      r, req0, req1, ack0, ack1, so, busy, gnt, done;
  logic [2:0][7:0] d0, d1;

  int errors = 0;
  int checks = 0;

  exp_t expq0[$];
  exp_t expq1[$];
  exp_t expq2[$];

  int unsigned phase [3];
  int unsigned cnt   [3];
  exp_t        cur   [3];
  logic        rprev [3];

  initial c = 1'b0;
  always #5 c = ~c;

  for (genvar g = 0; g < 3; g++) begin : gd
    serial_tx_arbiter #(
      .WIDTH(8),
      .DIV((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .C(c), .R(r[g]),
      .REQ0(req0[g]), .D0(d0[g]), .ACK0(ack0[g]),
      .REQ1(req1[g]), .D1(d1[g]), .ACK1(ack1[g]),
      .SO(so[g]), .BUSY(busy[g]), .GNT(gnt[g]), .DONE(done[g])
    );
  end

  function automatic int divof(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  function automatic int qsize(input int g);
    case (g)
      0: return expq0.size();
      1: return expq1.size();
      default: return expq2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int g);
    case (g)
      0: return expq0.pop_front();
      1: return expq1.pop_front();
      default: return expq2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int g, input logic idx, input logic [7:0] w);
    exp_t e;
    e.idx  = idx;
    e.word = w;
    case (g)
      0: expq0.push_back(e);
      1: expq1.push_back(e);
      default: expq2.push_back(e);
    endcase
  endtask

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
               name, g, act, expv, $time);
    end
  endtask

  task automatic shift_check(input int g);
    int         b;
    logic [7:0] wb;
    b  = 7 - int'(cnt[g]) / divof(g);
    wb = cur[g].word;
    chk("so_bit", g, 32'(so[g]), 32'(wb[b]));
    chk("busy_done_in_frame", g, 32'({busy[g], done[g]}), 32'b10);
    chk("gnt_in_frame", g, 32'(gnt[g]), 32'(cur[g].idx));
    cnt[g]++;
    phase[g] = (cnt[g] == 32'(8 * divof(g))) ? 2 : 1;
  endtask

  task automatic mon_one(input int g);
    if (rprev[g]) begin
      chk("reset_outs", g,
          32'({so[g], busy[g], done[g], ack0[g], ack1[g], gnt[g]}), 32'd0);
      phase[g] = 0;
    end else begin
      case (phase[g])
        0: begin
          if (ack0[g] | ack1[g]) begin
            chk("frame_expected", g, 32'(qsize(g) != 0), 32'd1);
            if (qsize(g) != 0) cur[g] = qpop(g);
            else cur[g] = '0;
            chk("ack_excl", g, 32'(ack0[g] & ack1[g]), 32'd0);
            chk("ack_idx", g, 32'(ack1[g]), 32'(cur[g].idx));
            cnt[g] = 0;
            shift_check(g);
          end else begin
            chk("idle_outs", g, 32'({so[g], busy[g], done[g]}), 32'd0);
          end
        end
        1: begin
          chk("no_ack_in_frame", g, 32'({ack0[g], ack1[g]}), 32'd0);
          shift_check(g);
        end
        2: begin
          chk("done_cycle", g,
              32'({so[g], busy[g], done[g], ack0[g], ack1[g]}), 32'b00100);
          phase[g] = 3;
        end
        default: begin
          chk("post_done_idle", g,
              32'({so[g], busy[g], done[g], ack0[g], ack1[g]}), 32'd0);
          phase[g] = 0;
        end
      endcase
    end
    rprev[g] = r[g];
  endtask

  task automatic monitor();
    for (int g = 0; g < 3; g++) begin
      phase[g] = 0;
      cnt[g]   = 0;
      rprev[g] = 1'b1;
    end
    forever begin
      @(negedge c);
      for (int g = 0; g < 3; g++) mon_one(g);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge c);
    #1;
  endtask

  // Waits (bounded) for an ACK on instance g, records its time and returns
  // just after the following rising edge.
  task automatic wait_ack(input int g, output time t);
    int n;
    n = 0;
    do begin
      @(negedge c);
      n++;
    end while (!(ack0[g] | ack1[g]) && n < 100);
    chk("ack_seen", g, 32'(ack0[g] | ack1[g]), 32'd1);
    t = $time;
    step(1);
  endtask

  task automatic stimulus();
    time ta[4];
    time t;
    r    = 3'b111;
    req0 = '0;
    req1 = '0;
    d0   = '0;
    d1   = '0;
    step(3);
    r = '0;
    step(2);

    // Single frame, DIV=1
    d0[0] = 8'hA5;
    qpush(0, 1'b0, 8'hA5);
    req0[0] = 1'b1;
    wait_ack(0, t);
    req0[0] = 1'b0;
    step(15);

    // D0 changes right after ACK0; captured word must be serialized
    d0[0] = 8'h3C;
    qpush(0, 1'b0, 8'h3C);
    req0[0] = 1'b1;
    wait_ack(0, t);
    req0[0] = 1'b0;
    d0[0]   = 8'hFF;
    step(15);

    // Short REQ0 pulse during a requester-1 frame is withdrawn
    d1[0] = 8'h5A;
    qpush(0, 1'b1, 8'h5A);
    req1[0] = 1'b1;
    wait_ack(0, t);
    req1[0] = 1'b0;
    step(2);
    d0[0]   = 8'h77;
    req0[0] = 1'b1;
    step(1);
    req0[0] = 1'b0;
    step(20);

    // Both requesters held, DIV=2: alternate 0,1,0,1 every 18 cycles
    d0[1] = 8'hFF;
    d1[1] = 8'h00;
    qpush(1, 1'b0, 8'hFF);
    qpush(1, 1'b1, 8'h00);
    qpush(1, 1'b0, 8'hFF);
    qpush(1, 1'b1, 8'h00);
    req0[1] = 1'b1;
    req1[1] = 1'b1;
    for (int i = 0; i < 4; i++) wait_ack(1, ta[i]);
    req0[1] = 1'b0;
    req1[1] = 1'b0;
    for (int i = 0; i < 3; i++)
      chk("frame_period", 1, 32'(ta[i+1] - ta[i]), 32'd180);
    step(40);

    // Requester 1 alone, DIV=4, 0x81
    d1[2] = 8'h81;
    qpush(2, 1'b1, 8'h81);
    req1[2] = 1'b1;
    wait_ack(2, t);
    req1[2] = 1'b0;
    step(40);

    // Reset in the 5th SHIFT cycle of a 0xC3 frame, then a tie
    d0[2] = 8'hC3;
    qpush(2, 1'b0, 8'hC3);
    req0[2] = 1'b1;
    wait_ack(2, t);
    req0[2] = 1'b0;
    step(3);
    r[2] = 1'b1;
    step(1);
    r[2] = 1'b0;
    step(2);
    d0[2] = 8'h11;
    d1[2] = 8'h22;
    qpush(2, 1'b0, 8'h11);
    req0[2] = 1'b1;
    req1[2] = 1'b1;
    wait_ack(2, t);
    req0[2] = 1'b0;
    req1[2] = 1'b0;
    step(40);

    for (int g = 0; g < 3; g++)
      chk("queue_drained", g, 32'(qsize(g)), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
